// File: rtl/display_pkg.sv
// Shared constants for the display path: layer indices, transparency key
// and the pixel slot-state encoding used by the ROM time-multiplexer.
package display_pkg;

  localparam int N_LAYERS    = 4;
  localparam int L_MOUSE     = 0;
  localparam int L_CARD      = 1;
  localparam int L_BUTTON    = 2;
  localparam int L_BG        = 3;
  localparam int SYNC_STAGES = 4;

  localparam logic [11:0] KEY_COLOR_DFLT = 12'h0F0;

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    IDLE = 3'd4
  } slot_e;

  // True when a fetched pixel is drawn rather than treated as see-through.
  function automatic logic is_opaque(input logic [11:0] px, input logic [11:0] key);
    return (px != key);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register for a VGA sync line; idles high out of reset.
module sync_delay #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sh_r;

  // Shift the sync line one stage per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_r <= {N{1'b1}};
    end else begin
      sh_r <= {sh_r[N-2:0], d};
    end
  end

  assign q = sh_r[N-1];

endmodule

// File: rtl/display_layer_sched.sv
// Shares the sprite ROM between four display layers (one read per clock,
// four clocks per pixel) and composites them by priority with colour keying.
module display_layer_sched
  import display_pkg::*;
#(
  parameter int          ADDR_W    = 17,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_stb,
  input  logic                       valid_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic [N_LAYERS-1:0]        layer_hit,
  input  logic [N_LAYERS*ADDR_W-1:0] layer_addr,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [11:0]                rom_data,
  output logic                       hsync,
  output logic                       vsync,
  output logic [3:0]                 vgaRed,
  output logic [3:0]                 vgaGreen,
  output logic [3:0]                 vgaBlue,
  output logic                       sync_err
);

  slot_e                       slot_r, slot_s;
  logic [N_LAYERS-1:0]         hit_r, hit_s;
  logic [N_LAYERS*ADDR_W-1:0]  addr_r, addr_s;
  logic                        valid_r, valid_s;
  logic [11:0]                 px_r [N_LAYERS-1];
  logic [11:0]                 px_s [N_LAYERS-1];
  logic [N_LAYERS-2:0]         op_r, op_s;
  logic                        rom_en_r, rom_en_s;
  logic [ADDR_W-1:0]           rom_addr_r, rom_addr_s;
  logic [11:0]                 rgb_r, rgb_s;
  logic                        sync_err_r, sync_err_s;
  logic [1:0]                  idx_s;
  logic                        issue_s;

  // Next-state: capture last slot's data, compose after slot 3, restart on strobe, pick next issue.
  always_comb begin
    slot_s     = slot_r;
    hit_s      = hit_r;
    addr_s     = addr_r;
    valid_s    = valid_r;
    px_s       = px_r;
    op_s       = op_r;
    rgb_s      = rgb_r;
    sync_err_s = sync_err_r;
    rom_en_s   = 1'b0;
    rom_addr_s = rom_addr_r;
    idx_s      = 2'd0;
    issue_s    = 1'b0;

    case (slot_r)
      S0: begin
        px_s[L_MOUSE] = rom_data;
        op_s[L_MOUSE] = rom_en_r && is_opaque(rom_data, KEY_COLOR);
      end
      S1: begin
        px_s[L_CARD] = rom_data;
        op_s[L_CARD] = rom_en_r && is_opaque(rom_data, KEY_COLOR);
      end
      S2: begin
        px_s[L_BUTTON] = rom_data;
        op_s[L_BUTTON] = rom_en_r && is_opaque(rom_data, KEY_COLOR);
      end
      S3: begin
        // Background data is still on the bus here, so it is used directly.
        if (!valid_r) begin
          rgb_s = 12'h000;
        end else if (op_r[L_MOUSE]) begin
          rgb_s = px_r[L_MOUSE];
        end else if (op_r[L_CARD]) begin
          rgb_s = px_r[L_CARD];
        end else if (op_r[L_BUTTON]) begin
          rgb_s = px_r[L_BUTTON];
        end else if (rom_en_r) begin
          rgb_s = rom_data;
        end else begin
          rgb_s = rgb_r;
        end
      end
      default: begin
        rgb_s = rgb_r;
      end
    endcase

    if (pix_stb) begin
      if ((slot_r == S0) || (slot_r == S1) || (slot_r == S2)) begin
        sync_err_s = 1'b1;
      end else begin
        sync_err_s = sync_err_r;
      end
      slot_s       = S0;
      hit_s        = layer_hit;
      hit_s[L_BG]  = 1'b1;
      addr_s       = layer_addr;
      valid_s      = valid_in;
    end else begin
      case (slot_r)
        S0:      slot_s = S1;
        S1:      slot_s = S2;
        S2:      slot_s = S3;
        S3:      slot_s = IDLE;
        default: slot_s = IDLE;
      endcase
    end

    case (slot_s)
      S0:      idx_s = 2'd0;
      S1:      idx_s = 2'd1;
      S2:      idx_s = 2'd2;
      S3:      idx_s = 2'd3;
      default: idx_s = 2'd0;
    endcase

    issue_s = (slot_s != IDLE) && valid_s && hit_s[idx_s];
    if (issue_s) begin
      rom_en_s   = 1'b1;
      rom_addr_s = addr_s[int'(idx_s)*ADDR_W +: ADDR_W];
    end else begin
      rom_en_s   = 1'b0;
      rom_addr_s = rom_addr_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r     <= IDLE;
      hit_r      <= {N_LAYERS{1'b0}};
      addr_r     <= {(N_LAYERS*ADDR_W){1'b0}};
      valid_r    <= 1'b0;
      px_r[0]    <= 12'h000;
      px_r[1]    <= 12'h000;
      px_r[2]    <= 12'h000;
      op_r       <= {(N_LAYERS-1){1'b0}};
      rom_en_r   <= 1'b0;
      rom_addr_r <= {ADDR_W{1'b0}};
      rgb_r      <= 12'h000;
      sync_err_r <= 1'b0;
    end else begin
      slot_r     <= slot_s;
      hit_r      <= hit_s;
      addr_r     <= addr_s;
      valid_r    <= valid_s;
      px_r       <= px_s;
      op_r       <= op_s;
      rom_en_r   <= rom_en_s;
      rom_addr_r <= rom_addr_s;
      rgb_r      <= rgb_s;
      sync_err_r <= sync_err_s;
    end
  end

  sync_delay #(.N(SYNC_STAGES)) u_hsync (
    .clk (clk),
    .rst (rst),
    .d   (hsync_in),
    .q   (hsync)
  );

  sync_delay #(.N(SYNC_STAGES)) u_vsync (
    .clk (clk),
    .rst (rst),
    .d   (vsync_in),
    .q   (vsync)
  );

  assign rom_en   = rom_en_r;
  assign rom_addr = rom_addr_r;
  assign vgaRed   = rgb_r[11:8];
  assign vgaGreen = rgb_r[7:4];
  assign vgaBlue  = rgb_r[3:0];
  assign sync_err = sync_err_r;

endmodule

// File: tb/tb_display_layer_sched.sv
// Randomised and directed bench for display_layer_sched against a
// cycle-count reference model of pixel timing, priority and keying.
module tb_display_layer_sched;

  localparam int          AW  = 17;
  localparam logic [11:0] KEY = 12'h0F0;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pix_stb = 1'b0;
  logic            valid_in = 1'b0;
  logic            hsync_in = 1'b1;
  logic            vsync_in = 1'b1;
  logic [3:0]      layer_hit = 4'h0;
  logic [4*AW-1:0] layer_addr = {(4*AW){1'b0}};
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [11:0]     rom_data = 12'h000;
  logic            hsync, vsync, sync_err;
  logic [3:0]      vgaRed, vgaGreen, vgaBlue;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] mem [64];
  int          cyc_n, last_start;
  logic        c_valid;
  logic [3:0]  c_hit;
  logic [4*AW-1:0] c_addr;
  logic [11:0] exp_rgb;
  logic        exp_en, exp_err, exp_hs, exp_vs;
  logic [AW-1:0] exp_addr;
  logic        hq[$];
  logic        vq[$];
  logic        hs_low = 1'b0;

  always #5 clk = ~clk;

  // ROM stand-in: read data settles mid-cycle, ready for the next edge.
  always @(negedge clk) rom_data = rom_en ? mem[rom_addr[5:0]] : 12'h5A5;

  display_layer_sched #(.ADDR_W(AW), .KEY_COLOR(KEY)) dut (
    .clk(clk), .rst(rst), .pix_stb(pix_stb), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_hit(layer_hit),
    .layer_addr(layer_addr), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .hsync(hsync), .vsync(vsync), .vgaRed(vgaRed),
    .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .sync_err(sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] mk(input int idx);
    logic [10:0] hi;
    hi = 11'($urandom);
    return {hi, 6'(idx)};
  endfunction

  function automatic logic [4*AW-1:0] addrs(input int i0, input int i1, input int i2, input int i3);
    return {mk(i3), mk(i2), mk(i1), mk(i0)};
  endfunction

  // Highest-priority covered layer whose colour is not the key; background always wins last.
  function automatic logic [11:0] model_rgb(input logic v, input logic [3:0] h, input logic [4*AW-1:0] a);
    logic [11:0] d;
    if (!v) return 12'h000;
    for (int k = 0; k < 3; k++) begin
      d = mem[a[k*AW +: 6]];
      if (h[k] && (d != KEY)) return d;
    end
    return mem[a[3*AW +: 6]];
  endfunction

  task automatic model_reset();
    cyc_n = 0; last_start = -100;
    exp_rgb = 12'h000; exp_en = 1'b0; exp_addr = {AW{1'b0}}; exp_err = 1'b0;
    hq = '{1'b1, 1'b1, 1'b1};
    vq = '{1'b1, 1'b1, 1'b1};
  endtask

  task automatic cyc(input logic stb, input logic v, input logic [3:0] h, input logic [4*AW-1:0] a);
    logic hs, vs;
    int   s;
    hs = hs_low ? 1'b0 : ($urandom_range(0, 5) != 0);
    vs = ($urandom_range(0, 9) != 0);
    pix_stb = stb; valid_in = v; layer_hit = h; layer_addr = a;
    hsync_in = hs; vsync_in = vs;
    @(posedge clk);
    s = cyc_n - last_start;
    if (s == 4) exp_rgb = model_rgb(c_valid, c_hit, c_addr);
    if (stb) begin
      if (s >= 1 && s <= 3) exp_err = 1'b1;
      last_start = cyc_n; c_valid = v; c_hit = h; c_addr = a;
    end
    s = cyc_n - last_start;
    exp_en = 1'b0;
    if (s >= 0 && s <= 3) begin
      if (c_valid && (s == 3 || c_hit[s])) begin
        exp_en = 1'b1;
        exp_addr = c_addr[s*AW +: AW];
      end
    end
    hq.push_back(hs); exp_hs = hq.pop_front();
    vq.push_back(vs); exp_vs = vq.pop_front();
    cyc_n++;
    #1;
    chk("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(exp_rgb));
    chk("rom_en", 32'(rom_en), 32'(exp_en));
    if (exp_en) chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    chk("sync_err", 32'(sync_err), 32'(exp_err));
    chk("hsync", 32'(hsync), 32'(exp_hs));
    chk("vsync", 32'(vsync), 32'(exp_vs));
  endtask

  task automatic pixel(input logic v, input logic [3:0] h, input int i0, input int i1,
                       input int i2, input int i3, input int len);
    cyc(1'b1, v, h, addrs(i0, i1, i2, i3));
    for (int k = 1; k < len; k++)
      cyc(1'b0, 1'($urandom), 4'($urandom),
          addrs($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rgb"}, 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'h0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_hsync"}, 32'(hsync), 32'h1);
    chk({tag, "_vsync"}, 32'(vsync), 32'h1);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'h0);
  endtask

  initial begin
    int len;
    model_reset();
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    mem[0] = 12'hF00; mem[1] = KEY; mem[2] = 12'h00F; mem[3] = KEY;
    mem[4] = 12'h123; mem[5] = 12'h456; mem[6] = 12'h789;

    #12;
    chk_reset_state("por");
    @(negedge clk); rst = 1'b1;

    // All layers hit, mouse opaque.
    pixel(1'b1, 4'b1111, 0, 4, 6, 5, 5);
    chk("t1_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0F00);
    // Mouse keyed out, card shows.
    pixel(1'b1, 4'b0011, 1, 2, 6, 5, 5);
    chk("t2_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h000F);
    // Nothing hit: background drawn even in key colour.
    pixel(1'b1, 4'b0000, 0, 4, 6, 3, 5);
    chk("t3_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h00F0);
    // Blanking.
    pixel(1'b0, 4'b1111, 0, 4, 6, 5, 5);
    chk("t4_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0000);
    // Early strobe aborts the mouse pixel; the following pixel composes.
    pixel(1'b1, 4'b1111, 0, 4, 6, 5, 2);
    pixel(1'b1, 4'b0011, 1, 4, 6, 5, 5);
    chk("t5_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0123);
    chk("t5_sync_err", 32'(sync_err), 32'h1);

    // Back-to-back pixels.
    for (int p = 0; p < 6; p++)
      pixel(1'b1, 4'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom_range(0, 63), 4);

    // Reset asserted during slot 2 with non-idle outputs.
    hs_low = 1'b1;
    pixel(1'b1, 4'b1111, 0, 4, 6, 5, 5);
    cyc(1'b1, 1'b1, 4'b1111, addrs(0, 4, 6, 5));
    cyc(1'b0, 1'b0, 4'b0000, addrs(0, 0, 0, 0));
    cyc(1'b0, 1'b0, 4'b0000, addrs(0, 0, 0, 0));
    rst = 1'b0;
    #1;
    chk_reset_state("mid");
    model_reset();
    hs_low = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    pixel(1'b1, 4'b0011, 1, 2, 6, 5, 5);
    chk("t6_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h000F);

    // Random traffic, including occasional early strobes and idle gaps.
    for (int p = 0; p < 150; p++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 6));
      pixel(($urandom_range(0, 5) != 0), 4'($urandom), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), len);
    end
    repeat (6) cyc(1'b0, 1'b0, 4'h0, addrs(0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
